// File: rtl/entry_pkg.sv
// Shared types and constants for the digit entry front end.
//   digit_idx_t : index of one display digit (0..7)
//   nibble_t    : value stored in one digit
//   deb_state_t : button debouncer states
//   ctl_state_t : top-level entry controller states
//   NUM_DIGITS  : digits in the display
`timescale 1ns/1ps
package entry_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [2:0] digit_idx_t;
    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        DEB_IDLE         = 2'd0,
        DEB_PRESS_WAIT   = 2'd1,
        DEB_PRESSED      = 2'd2,
        DEB_RELEASE_WAIT = 2'd3
    } deb_state_t;

    typedef enum logic {
        CTL_IDLE     = 1'b0,
        CTL_CLEARING = 1'b1
    } ctl_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one raw push-button.
//   clk, reset : system clock, asynchronous active-high reset
//   raw        : raw asynchronous button level
//   press      : one-cycle registered pulse per accepted press
// A press is accepted after the synchronized level has been 1 for
// DEBOUNCE_CYCLES+1 consecutive samples (entry sample plus DEBOUNCE_CYCLES
// counted ones). Release is debounced the same way, so holding the button
// yields exactly one pulse. DEBOUNCE_CYCLES must be at least 2.
`timescale 1ns/1ps
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    import entry_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter reaches DEBOUNCE_CYCLES on the same edge the transition
    // is taken, so the last stored value is DEBOUNCE_CYCLES-1 and it never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level;
    logic [CNT_W-1:0] cnt;
    deb_state_t       state;

    assign level = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DEB_IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                DEB_IDLE: begin
                    cnt <= '0;
                    if (level) state <= DEB_PRESS_WAIT;
                end
                DEB_PRESS_WAIT: begin
                    if (!level) begin
                        state <= DEB_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DEB_PRESSED;
                        cnt   <= '0;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEB_PRESSED: begin
                    cnt <= '0;
                    if (!level) state <= DEB_RELEASE_WAIT;
                end
                DEB_RELEASE_WAIT: begin
                    if (level) begin
                        state <= DEB_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DEB_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= DEB_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Front-end input controller for the 8-digit seven-segment display.
//   clk, reset         : system clock, asynchronous active-high reset
//   btn_enter          : raw enter button (bouncy)
//   btn_clear          : raw clear button (bouncy)
//   sw_num  [3:0]      : raw value switches
//   sw_sel  [2:0]      : raw digit-select switches (manual mode)
//   sw_auto            : raw mode switch, 1 = auto-advance cursor
//   write              : one-cycle write strobe to the display stage
//   sel     [2:0]      : target digit
//   num     [3:0]      : value to store
//   cursor  [2:0]      : next digit auto mode will write
//   busy               : full-display clear in progress
// Output stream: write is a single-cycle strobe; sel/num are meaningful only
// while write=1 and otherwise hold their last values. There is no ready
// signal -- the display register stage accepts every strobe.
`timescale 1ns/1ps
module digit_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NUM_DIGITS      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic [3:0] sw_num,
    input  logic [2:0] sw_sel,
    input  logic       sw_auto,
    output logic       write,
    output logic [2:0] sel,
    output logic [3:0] num,
    output logic [2:0] cursor,
    output logic       busy
);
    import entry_pkg::*;

    localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    nibble_t    num_meta, num_s;
    digit_idx_t sel_meta, sel_s;
    logic       auto_meta, auto_s;

    logic       enter_press;
    logic       clear_press;

    ctl_state_t state;
    digit_idx_t clr_idx;
    digit_idx_t target;

    // Switches are level inputs; two flops are enough, no debouncing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_meta  <= '0;
            num_s     <= '0;
            sel_meta  <= '0;
            sel_s     <= '0;
            auto_meta <= 1'b0;
            auto_s    <= 1'b0;
        end else begin
            num_meta  <= sw_num;
            num_s     <= num_meta;
            sel_meta  <= sw_sel;
            sel_s     <= sel_meta;
            auto_meta <= sw_auto;
            auto_s    <= auto_meta;
        end
    end

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_deb (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_enter),
        .press (enter_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_deb (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_clear),
        .press (clear_press)
    );

    assign target = auto_s ? cursor : sel_s;

    // clr_idx holds the digit being written in the current clear cycle.
    // Clear wins over a simultaneous enter; presses during CLEARING are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CTL_IDLE;
            clr_idx <= '0;
            write   <= 1'b0;
            sel     <= '0;
            num     <= '0;
            cursor  <= '0;
            busy    <= 1'b0;
        end else begin
            write <= 1'b0;
            case (state)
                CTL_IDLE: begin
                    if (clear_press) begin
                        state   <= CTL_CLEARING;
                        busy    <= 1'b1;
                        clr_idx <= '0;
                        write   <= 1'b1;
                        sel     <= '0;
                        num     <= '0;
                    end else if (enter_press) begin
                        write  <= 1'b1;
                        sel    <= target;
                        num    <= num_s;
                        cursor <= target + 3'd1;
                    end
                end
                CTL_CLEARING: begin
                    if (clr_idx == LAST_DIGIT) begin
                        state   <= CTL_IDLE;
                        busy    <= 1'b0;
                        cursor  <= '0;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 3'd1;
                        write   <= 1'b1;
                        sel     <= clr_idx + 3'd1;
                        num     <= '0;
                    end
                end
                default: begin
                    state <= CTL_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
